// File: rtl/matrix_writer.sv
// matrix_writer
//
// Streaming window writer. It accepts one 8-bit pixel per valid/ready handshake
// and stores it into a SIZE x SIZE matrix in raster order: x advances fastest,
// then y. When the last cell (SIZE-1, SIZE-1) is written, the window is marked
// complete. The writer then holds the matrix frozen until the consumer pulses
// window_consume. The output matrix is addressed out[x][y], which matches the
// indexed matrix reader downstream.
//
// Ports
//   clk            system clock, rising-edge active
//   rst            synchronous active-high reset; returns all state and out to zero
//   pix_in         pixel value offered this cycle
//   pix_valid      pix_in is valid this cycle
//   pix_ready      writer accepts a pixel this cycle (combinational, gated by clear)
//   clear          synchronous abort of the current fill; out is left untouched
//   window_consume one-cycle pulse: the consumer has taken the window
//   out            window matrix, out[x][y]
//   window_valid   out holds a complete window
//   cur_x, cur_y   cell that the next accepted pixel will be written to

module matrix_writer #(
  parameter int unsigned SIZE = 3  // legal range 2..15
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [7:0]                       pix_in,
  input  logic                             pix_valid,
  output logic                             pix_ready,
  input  logic                             clear,
  input  logic                             window_consume,
  output logic [SIZE-1:0][SIZE-1:0][7:0]   out,
  output logic                             window_valid,
  output logic [3:0]                       cur_x,
  output logic [3:0]                       cur_y
);

  // Width of an index into one matrix dimension.
  localparam int unsigned IdxW = $clog2(SIZE);
  localparam logic [3:0]  Last = 4'(SIZE - 1);

  typedef enum logic [0:0] {
    StFill,
    StFull
  } state_e;

  state_e                           state_q, state_d;
  logic [3:0]                       cur_x_q, cur_x_d;
  logic [3:0]                       cur_y_q, cur_y_d;
  logic [SIZE-1:0][SIZE-1:0][7:0]   out_q, out_d;

  logic            accept;
  logic [IdxW-1:0] sel_x;
  logic [IdxW-1:0] sel_y;

  // pix_ready already excludes clear, so an accept can never coincide with an abort.
  assign pix_ready = (state_q == StFill) && !clear;
  assign accept    = pix_valid && pix_ready;

  // The counters never exceed SIZE-1, so the dropped upper bits are always zero.
  assign sel_x = cur_x_q[IdxW-1:0];
  assign sel_y = cur_y_q[IdxW-1:0];

  // Next-state logic for the FSM, the raster counters and the matrix.
  always_comb begin
    state_d = state_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    out_d   = out_q;

    if (clear) begin
      // Abort the fill. Keep the stale matrix; a new fill overwrites it in place.
      state_d = StFill;
      cur_x_d = '0;
      cur_y_d = '0;
    end else begin
      unique case (state_q)
        StFill: begin
          if (accept) begin
            out_d[sel_x][sel_y] = pix_in;
            if (cur_x_q == Last) begin
              cur_x_d = '0;
              if (cur_y_q == Last) begin
                cur_y_d = '0;
                state_d = StFull;
              end else begin
                cur_y_d = cur_y_q + 4'd1;
              end
            end else begin
              cur_x_d = cur_x_q + 4'd1;
            end
          end
        end
        StFull: begin
          if (window_consume) begin
            state_d = StFill;
          end
        end
        default: state_d = StFill;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFill;
      cur_x_q <= '0;
      cur_y_q <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      out_q   <= out_d;
    end
  end

  // A window is complete exactly while the writer sits in FULL.
  assign window_valid = (state_q == StFull);
  assign out          = out_q;
  assign cur_x        = cur_x_q;
  assign cur_y        = cur_y_q;

endmodule

// File: tb/tb_matrix_writer.sv
// Testbench for matrix_writer. It drives a SIZE=3 and a SIZE=5 instance from the
// same stimulus. A directed sequence runs first, followed by a randomized
// phase. Every cycle is compared against a reference model. The model tracks
// the number of pixels accepted in the current fill and derives the expected
// (x, y) position from that count with div/mod arithmetic.

module tb_matrix_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pix_in;
  logic       pix_valid;
  logic       clear;
  logic       window_consume;

  logic                 ready3, valid3, ready5, valid5;
  logic [3:0]           cx3, cy3, cx5, cy5;
  logic [2:0][2:0][7:0] out3;
  logic [4:0][4:0][7:0] out5;

  always #5 clk = ~clk;

  matrix_writer #(.SIZE(3)) dut3 (
    .clk            (clk),
    .rst            (rst),
    .pix_in         (pix_in),
    .pix_valid      (pix_valid),
    .pix_ready      (ready3),
    .clear          (clear),
    .window_consume (window_consume),
    .out            (out3),
    .window_valid   (valid3),
    .cur_x          (cx3),
    .cur_y          (cy3)
  );

  matrix_writer #(.SIZE(5)) dut5 (
    .clk            (clk),
    .rst            (rst),
    .pix_in         (pix_in),
    .pix_valid      (pix_valid),
    .pix_ready      (ready5),
    .clear          (clear),
    .window_consume (window_consume),
    .out            (out5),
    .window_valid   (valid5),
    .cur_x          (cx5),
    .cur_y          (cy5)
  );

  // Reference model: per instance, a cell array, an accepted-pixel count and a full flag.
  logic [7:0] mem [2][15][15];
  int         cnt [2];
  bit         full [2];
  int         sz [2] = '{3, 5};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      cnt[i]  = 0;
      full[i] = 1'b0;
      for (int x = 0; x < 15; x++)
        for (int y = 0; y < 15; y++) mem[i][x][y] = 8'h00;
    end
  endtask

  task automatic model_edge(input logic v, input logic [7:0] d, input logic clr,
                            input logic cons, input logic r);
    if (r) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (clr) begin
          cnt[i]  = 0;
          full[i] = 1'b0;
        end else if (full[i]) begin
          if (cons) full[i] = 1'b0;
        end else if (v) begin
          mem[i][cnt[i] % sz[i]][cnt[i] / sz[i]] = d;
          cnt[i]++;
          if (cnt[i] == sz[i] * sz[i]) begin
            cnt[i]  = 0;
            full[i] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic check_state();
    for (int i = 0; i < 2; i++) begin
      logic [3:0] gx, gy;
      logic       gv;
      gx = (i == 0) ? cx3 : cx5;
      gy = (i == 0) ? cy3 : cy5;
      gv = (i == 0) ? valid3 : valid5;
      check_val($sformatf("s%0d_cur_x", sz[i]), 32'(gx), 32'(cnt[i] % sz[i]));
      check_val($sformatf("s%0d_cur_y", sz[i]), 32'(gy), 32'(cnt[i] / sz[i]));
      check_val($sformatf("s%0d_window_valid", sz[i]), 32'(gv), 32'(full[i]));
      for (int x = 0; x < sz[i]; x++)
        for (int y = 0; y < sz[i]; y++)
          check_val($sformatf("s%0d_out[%0d][%0d]", sz[i], x, y),
                    32'((i == 0) ? out3[x][y] : out5[x][y]), 32'(mem[i][x][y]));
    end
  endtask

  // One clock cycle: drive at the falling edge, check the combinational ready,
  // let the rising edge happen, then check registered state at the next falling edge.
  task automatic step(input logic v, input logic [7:0] d, input logic clr,
                      input logic cons, input logic r);
    pix_valid      = v;
    pix_in         = d;
    clear          = clr;
    window_consume = cons;
    rst            = r;
    #1;
    if (!r) begin
      check_val("s3_pix_ready", 32'(ready3), 32'(!full[0] && !clr));
      check_val("s5_pix_ready", 32'(ready5), 32'(!full[1] && !clr));
    end
    @(posedge clk);
    model_edge(v, d, clr, cons, r);
    @(negedge clk);
    check_state();
  endtask

  initial begin
    pix_valid = 1'b0; pix_in = '0; clear = 1'b0; window_consume = 1'b0; rst = 1'b1;
    model_reset();
    @(negedge clk);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // Full fill with 1..9 on consecutive cycles.
    for (int k = 1; k <= 9; k++) step(1, 8'(k), 0, 0, 0);
    check_val("fill_out00", 32'(out3[0][0]), 32'd1);
    check_val("fill_out10", 32'(out3[1][0]), 32'd2);
    check_val("fill_out20", 32'(out3[2][0]), 32'd3);
    check_val("fill_out01", 32'(out3[0][1]), 32'd4);
    check_val("fill_out11", 32'(out3[1][1]), 32'd5);
    check_val("fill_out22", 32'(out3[2][2]), 32'd9);
    check_val("fill_valid", 32'(valid3), 32'd1);

    // Backpressure while FULL.
    for (int k = 0; k < 5; k++) step(1, 8'hAA, 0, 0, 0);
    check_val("bp_out00", 32'(out3[0][0]), 32'd1);
    check_val("bp_cur_x", 32'(cx3), 32'd0);
    step(0, 0, 0, 1, 0);
    check_val("consume_valid", 32'(valid3), 32'd0);
    step(1, 8'd50, 0, 0, 0);
    check_val("after_consume_out00", 32'(out3[0][0]), 32'd50);

    // Gapped input after an abort.
    step(0, 0, 1, 0, 0);
    begin
      logic [7:0] gap_vals [9] = '{8'd25, 8'd100, 8'd25, 8'd50, 8'd150, 8'd50, 8'd25, 8'd100, 8'd25};
      for (int k = 0; k < 9; k++) begin
        step(1, gap_vals[k], 0, 0, 0);
        step(0, 0, 0, 0, 0);
      end
    end
    check_val("gap_out11", 32'(out3[1][1]), 32'd150);
    check_val("gap_valid", 32'(valid3), 32'd1);
    step(0, 0, 0, 1, 0);

    // Abort after 4 accepted pixels while a pixel is presented.
    for (int k = 0; k < 4; k++) step(1, 8'(200 + k), 0, 0, 0);
    step(1, 8'h77, 1, 0, 0);
    check_val("clear_cur_x", 32'(cx3), 32'd0);
    check_val("clear_out00", 32'(out3[0][0]), 32'd200);
    for (int k = 0; k < 9; k++) step(1, 8'(60 + k), 0, 0, 0);
    check_val("refill_valid", 32'(valid3), 32'd1);

    // clear together with consume while FULL.
    step(0, 0, 1, 1, 0);
    check_val("clr_cons_valid", 32'(valid3), 32'd0);

    // Reset in the middle of a fill.
    for (int k = 0; k < 5; k++) step(1, 8'(k + 11), 0, 0, 0);
    step(1, 8'h99, 1, 1, 1);
    check_val("rst_out11", 32'(out3[1][1]), 32'd0);

    // SIZE=5 fill with 0..24.
    for (int k = 0; k < 25; k++) step(1, 8'(k), 0, 0, 0);
    check_val("s5_out40", 32'(out5[4][0]), 32'd4);
    check_val("s5_out01", 32'(out5[0][1]), 32'd5);
    check_val("s5_out44", 32'(out5[4][4]), 32'd24);
    check_val("s5_valid", 32'(valid5), 32'd1);

    // Randomized phase.
    for (int k = 0; k < 1500; k++) begin
      logic v, c, w, r;
      v = ($urandom_range(99) < 70);
      c = ($urandom_range(99) < 3);
      w = ($urandom_range(99) < 20);
      r = ($urandom_range(999) < 5);
      step(v, 8'($urandom), c, w, r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
